instr_fetch: RTL and testbench

Instruction fetch unit that acts as the read initiator for the byte-wide 8K instruction memory. It walks a 13-bit PC and issues one byte read per cycle. It assembles one- or two-byte instructions into a 2-entry output queue with a valid/ready handshake toward decode. Redirects from the control unit flush all in-flight state.

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 149 ++++++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: byte-wide instruction memory read port plus the
// decode-facing instruction handshake and control-unit redirect.
interface instr_fetch_if #(
   parameter int unsigned ADDR_W = 13
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_writer;
   logic [7:0]        mem_data;
   logic [15:0]       instr;
   logic              instr_two;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;

   modport master (
      output mem_addr, mem_read, mem_writer,
      output instr, instr_two, instr_pc, instr_valid,
      input  mem_data, instr_ready, redirect, redirect_addr
   );

   modport slave (
      input  mem_addr, mem_read, mem_writer,
      input  instr, instr_two, instr_pc, instr_valid,
      output mem_data, instr_ready, redirect, redirect_addr
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: walks the PC one byte per cycle, assembles one/two-byte
// instructions into a small in-order queue toward decode, flushes on redirect.
module instr_fetch #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DEPTH  = 2
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH0 = 2'd1,
      FETCH1 = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0]       instr;
      logic              two;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [ADDR_W-1:0] start_pc, start_pc_n;
   logic [7:0]        byte0, byte0_n;
   logic [CNT_W-1:0]  count, count_n;
   logic              valid, valid_n;
   entry_t            q   [DEPTH];
   entry_t            q_n [DEPTH];

   logic              issue_c;
   logic              push_c;
   logic              pop_c;
   entry_t            push_e_c;

   // Fetch sequencing; a byte0 is only issued once queue space is guaranteed
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      start_pc_n = start_pc;
      byte0_n    = byte0;
      issue_c    = 1'b0;
      push_c     = 1'b0;
      push_e_c   = '0;

      case (state)
         IDLE: begin
            state_n = FETCH0;
         end
         FETCH0: begin
            if ((count < CNT_W'(DEPTH)) || bus.instr_ready) begin
               issue_c    = 1'b1;
               byte0_n    = bus.mem_data;
               start_pc_n = pc;
               pc_n       = pc + ADDR_W'(1);
               if (bus.mem_data[7]) begin
                  state_n = FETCH1;
               end else begin
                  push_c         = 1'b1;
                  push_e_c.instr = {bus.mem_data, 8'h00};
                  push_e_c.two   = 1'b0;
                  push_e_c.pc    = pc;
               end
            end
         end
         FETCH1: begin
            issue_c        = 1'b1;
            pc_n           = pc + ADDR_W'(1);
            push_c         = 1'b1;
            push_e_c.instr = {byte0, bus.mem_data};
            push_e_c.two   = 1'b1;
            push_e_c.pc    = start_pc;
            state_n        = FETCH0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (bus.redirect) begin
         state_n = FETCH0;
         pc_n    = bus.redirect_addr;
      end
   end

   // Shift queue: entry 0 is always the head, so head outputs come straight from flops
   always_comb begin
      pop_c   = valid && bus.instr_ready;
      q_n     = q;
      count_n = count;

      if (pop_c) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            q_n[i] = q[i + 1];
         end
         count_n = count - CNT_W'(1);
      end

      if (push_c) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (count_n == CNT_W'(i)) begin
               q_n[i] = push_e_c;
            end
         end
         count_n = count_n + CNT_W'(1);
      end

      if (bus.redirect) begin
         count_n = '0;
      end

      valid_n = (count_n != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= '0;
         start_pc <= '0;
         byte0    <= '0;
         count    <= '0;
         valid    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q[i] <= '0;
         end
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         start_pc <= start_pc_n;
         byte0    <= byte0_n;
         count    <= count_n;
         valid    <= valid_n;
         q        <= q_n;
      end
   end

   // Memory read port follows the issue decision in the same cycle
   assign bus.mem_read    = issue_c;
   assign bus.mem_addr    = pc;
   assign bus.mem_writer  = 1'b0;

   assign bus.instr       = q[0].instr;
   assign bus.instr_two   = q[0].two;
   assign bus.instr_pc    = q[0].pc;
   assign bus.instr_valid = valid;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory, instruction-stream reference
// model feeding a scoreboard, directed timing checks and random redirects.
module tb_instr_fetch;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned MEM_SZ = 8192;

   typedef struct {
      logic [15:0] instr;
      logic        two;
      logic [12:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();
   instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] mem [MEM_SZ];
   assign bus.mem_data = mem[bus.mem_addr];

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Reference: decode the byte stream from a start address using the length rule
   task automatic gen(input logic [12:0] start, input int n);
      logic [12:0] a;
      logic [7:0]  b0;
      exp_t        e;
      a = start;
      for (int k = 0; k < n; k++) begin
         b0   = mem[a];
         e.pc = a;
         if (b0[7]) begin
            e.instr = {b0, mem[13'(a + 13'd1)]};
            e.two   = 1'b1;
            a       = a + 13'd2;
         end else begin
            e.instr = {b0, 8'h00};
            e.two   = 1'b0;
            a       = a + 13'd1;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic restart(input logic [12:0] a);
      exp_q.delete();
      gen(a, 64);
   endtask

   // Monitor: pops the scoreboard on every accepted instruction, checks head stability
   exp_t        mon_e;
   logic        hold_v = 1'b0;
   logic [15:0] hold_instr;
   logic        hold_two;
   logic [12:0] hold_pc;

   always @(negedge clk) begin
      #2;
      if (rst && !bus.redirect) begin
         if (hold_v && bus.instr_valid)
            chk("head_stable", {2'b0, bus.instr_two, bus.instr_pc, bus.instr},
                {2'b0, hold_two, hold_pc, hold_instr});
         if (bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got instr %h pc %h, nothing expected",
                        bus.instr, bus.instr_pc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_instr", {2'b0, bus.instr_two, bus.instr_pc, bus.instr},
                   {2'b0, mon_e.two, mon_e.pc, mon_e.instr});
            end
         end
      end
      hold_v     = rst && !bus.redirect && bus.instr_valid && !bus.instr_ready;
      hold_instr = bus.instr;
      hold_two   = bus.instr_two;
      hold_pc    = bus.instr_pc;
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({tag, "_instr"}, 32'(bus.instr), 32'd0);
      chk({tag, "_two"}, 32'(bus.instr_two), 32'd0);
      chk({tag, "_pc"}, 32'(bus.instr_pc), 32'd0);
      chk({tag, "_writer"}, 32'(bus.mem_writer), 32'd0);
   endtask

   int unsigned lat;
   logic [12:0] ra;

   initial begin
      for (int i = 0; i < int'(MEM_SZ); i++) mem[i] = 8'($urandom);
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
      rst = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_addr = '0;
      bus.instr_ready = 1'b1;

      // Power-on reset, release, one-byte stream latency and throughput
      repeat (2) @(negedge clk);
      #2 chk_zero_outputs("rst0");
      @(negedge clk); rst = 1'b1; restart(13'd0);
      #2 chk("idle_no_read", 32'(bus.mem_read), 32'd0);
      @(negedge clk); #2;
      chk("rel1_read", 32'(bus.mem_read), 32'd1);
      chk("rel1_addr", 32'(bus.mem_addr), 32'd0);
      chk("rel1_valid", 32'(bus.instr_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #2;
         chk("seq_valid", 32'(bus.instr_valid), 32'd1);
         chk("seq_instr", 32'(bus.instr), 32'((k + 1) << 8));
         chk("seq_pc", 32'(bus.instr_pc), 32'(k));
         chk("seq_two", 32'(bus.instr_two), 32'd0);
      end

      // Mid-stream reset, then a two-byte instruction at address 0
      repeat (3) @(negedge clk);
      rst = 1'b0; exp_q.delete();
      mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'h07;
      #2 chk_zero_outputs("rst_mid");
      @(negedge clk); rst = 1'b1; restart(13'd0);
      @(negedge clk); #2 chk("two_v1", 32'(bus.instr_valid), 32'd0);
      @(negedge clk); #2;
      chk("two_v2", 32'(bus.instr_valid), 32'd0);
      chk("two_f1_addr", 32'(bus.mem_addr), 32'd1);
      @(negedge clk); #2;
      chk("two_valid", 32'(bus.instr_valid), 32'd1);
      chk("two_instr", 32'(bus.instr), 32'h853C);
      chk("two_flag", 32'(bus.instr_two), 32'd1);
      chk("two_pc", 32'(bus.instr_pc), 32'd0);
      @(negedge clk); #2 chk("two_next_pc", 32'(bus.instr_pc), 32'd2);

      // Backpressure: queue fills to two entries, fetch stalls, then streams
      @(negedge clk);
      for (int k = 0; k < 8; k++) mem[13'h100 + k] = 8'(8'h10 + k);
      bus.redirect = 1'b1; bus.redirect_addr = 13'h100; bus.instr_ready = 1'b0;
      restart(13'h100);
      @(negedge clk); bus.redirect = 1'b0;
      #2 chk("bp_first_addr", 32'(bus.mem_addr), 32'h100);
      repeat (3) @(negedge clk);
      #2;
      chk("bp_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_head", 32'(bus.instr), 32'h1000);
      chk("bp_stall_read", 32'(bus.mem_read), 32'd0);
      chk("bp_stall_addr", 32'(bus.mem_addr), 32'h102);
      @(negedge clk); #2;
      chk("bp_hold_addr", 32'(bus.mem_addr), 32'h102);
      chk("bp_hold_read", 32'(bus.mem_read), 32'd0);
      @(negedge clk); bus.instr_ready = 1'b1;
      #2;
      chk("bp_full_read", 32'(bus.mem_read), 32'd1);
      chk("bp_full_addr", 32'(bus.mem_addr), 32'h102);
      @(negedge clk); #2;
      chk("bp_after_pc", 32'(bus.instr_pc), 32'h101);
      chk("bp_after_read", 32'(bus.mem_read), 32'd1);
      chk("bp_after_addr", 32'(bus.mem_addr), 32'h103);

      // Redirect during FETCH1 of a two-byte instruction
      @(negedge clk);
      mem[13'h200] = 8'h9A; mem[13'h201] = 8'h55;
      bus.redirect = 1'b1; bus.redirect_addr = 13'h200; restart(13'h200);
      @(negedge clk); bus.redirect = 1'b0;
      @(negedge clk);
      bus.redirect = 1'b1; bus.redirect_addr = 13'h1234; restart(13'h1234);
      #2;
      chk("rf1_read", 32'(bus.mem_read), 32'd1);
      chk("rf1_addr", 32'(bus.mem_addr), 32'h201);
      @(negedge clk); bus.redirect = 1'b0;
      #2;
      chk("rf1_flushed", 32'(bus.instr_valid), 32'd0);
      chk("rf1_new_addr", 32'(bus.mem_addr), 32'h1234);
      chk("rf1_new_read", 32'(bus.mem_read), 32'd1);
      lat = mem[13'h1234][7] ? 2 : 1;
      repeat (lat) @(negedge clk);
      #2;
      chk("rf1_new_valid", 32'(bus.instr_valid), 32'd1);
      chk("rf1_new_pc", 32'(bus.instr_pc), 32'h1234);

      // Two-byte instruction straddling the top of memory
      @(negedge clk);
      mem[8191] = 8'h81; mem[0] = 8'h10;
      bus.redirect = 1'b1; bus.redirect_addr = 13'd8191; restart(13'd8191);
      @(negedge clk); bus.redirect = 1'b0;
      #2;
      chk("wrap_addr0", 32'(bus.mem_addr), 32'd8191);
      chk("wrap_valid0", 32'(bus.instr_valid), 32'd0);
      @(negedge clk); #2;
      chk("wrap_addr1", 32'(bus.mem_addr), 32'd0);
      @(negedge clk); #2;
      chk("wrap_valid", 32'(bus.instr_valid), 32'd1);
      chk("wrap_instr", 32'(bus.instr), 32'h8110);
      chk("wrap_pc", 32'(bus.instr_pc), 32'd8191);
      chk("wrap_next_addr", 32'(bus.mem_addr), 32'd1);

      // Random segments: random restart points, ready patterns and resets
      for (int seg = 0; seg < 40; seg++) begin
         @(negedge clk);
         bus.instr_ready = ($urandom_range(0, 3) != 0);
         if (seg % 7 == 3) begin
            rst = 1'b0; exp_q.delete();
            @(negedge clk);
            rst = 1'b1; restart(13'd0);
         end else begin
            ra = (seg % 4 == 1) ? 13'($urandom_range(8185, 8191)) : 13'($urandom);
            bus.redirect = 1'b1; bus.redirect_addr = ra; restart(ra);
            @(negedge clk); bus.redirect = 1'b0;
         end
         repeat ($urandom_range(5, 35)) begin
            @(negedge clk);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
         end
      end

      repeat (4) @(negedge clk);
      #2 chk("writer_zero", 32'(bus.mem_writer), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
